fetch_prefetch_unit: RTL and testbench

//  Instruction fetch stage with a parametrised prefetch queue and a full request/accept/response memory handshake.

---
 rtl/fetch_pkg.sv | 9 +
 rtl/fetch_fifo.sv | 46 ++++
 rtl/fetch_prefetch_unit.sv | 79 +++++++
 tb/tb_fetch_prefetch_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding, instruction size and queue entry layout for the fetch stage
package fetch_pkg;
   localparam int INSTR_BYTES = 4;
   typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} fetch_state_t;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ir;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: prefetch queue with push/pop/flush and occupancy count
//   push_i/din_i   write an entry (dropped when full with no pop on the same edge)
//   pop_i          advance the head (ignored when empty)
//   flush_i        empty the queue; wins over push and pop
//   dout_o         head entry, count_o current occupancy
module fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   input  logic [WIDTH-1:0]       din_i,
   output logic [WIDTH-1:0]       dout_o,
   output logic [$clog2(DEPTH):0] count_o
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0] wp_q, rp_q;
   logic [AW:0] count_q;
   logic push_ok, pop_ok;
   assign pop_ok = pop_i & (count_q != '0);
   assign push_ok = push_i & ((count_q != (AW+1)'(DEPTH)) | pop_ok);
   assign dout_o = mem_q[rp_q];
   assign count_o = count_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wp_q <= '0;
         rp_q <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (flush_i) begin
         wp_q <= '0;
         rp_q <= '0;
         count_q <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wp_q] <= din_i;
            wp_q <= wp_q + AW'(1);
         end
         if (pop_ok) rp_q <= rp_q + AW'(1);
         count_q <= count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
      end
endmodule

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: instruction fetch stage running ahead of decode through a prefetch queue
//   j/jPC                  redirect: flush queue, squash in-flight response, refetch from jPC & ~3
//   proc_req/addr/mem_rdy  request/accept handshake, at most one read in flight
//   valid/Rdata            response to the accepted request
//   if_valid/id_ready      head handshake toward decode; IR/PC/NPC are 0 when if_valid=0
//   we                     tied 0, fetch never writes
module fetch_prefetch_unit
   import fetch_pkg::*;
#(
   parameter int              bits     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [bits-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            j,
   input  logic [bits-1:0] jPC,
   input  logic            mem_rdy,
   input  logic            valid,
   input  logic [bits-1:0] Rdata,
   output logic            proc_req,
   output logic            we,
   output logic [bits-1:0] addr,
   output logic            if_valid,
   input  logic            id_ready,
   output logic [bits-1:0] IR,
   output logic [bits-1:0] PC,
   output logic [bits-1:0] NPC
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [bits-1:0] STEP = bits'(INSTR_BYTES);
   fetch_state_t state_q;
   logic [bits-1:0] fetch_pc_q, jpc_al;
   logic [2*bits-1:0] head;
   logic [CW-1:0] count, cnt_nx;
   logic push, pop, accept;
   assign jpc_al = jPC & ~bits'(3);
   assign if_valid = count != '0;
   assign pop = if_valid & id_ready;
   assign push = (state_q == WAIT) & valid & ~j;
   assign accept = proc_req & mem_rdy;
   // occupancy after this edge; a request may only follow a push if this leaves a free slot
   assign cnt_nx = count + CW'(push) - CW'(pop);
   assign proc_req = state_q == REQ;
   assign we = 1'b0;
   assign addr = fetch_pc_q;
   assign IR = if_valid ? head[2*bits-1:bits] : '0;
   assign PC = if_valid ? head[bits-1:0] : '0;
   assign NPC = if_valid ? head[bits-1:0] + STEP : '0;
   fetch_fifo #(.WIDTH(2*bits), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (j),
      .din_i   ({Rdata, fetch_pc_q}),
      .dout_o  (head),
      .count_o (count)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         fetch_pc_q <= RESET_PC;
      end else if (j) begin
         // an accepted-but-unanswered request must have its response dropped
         fetch_pc_q <= jpc_al;
         state_q <= (state_q == IDLE || (state_q == REQ && !accept) || (state_q != REQ && valid)) ? REQ : DROP;
      end else begin
         case (state_q)
            IDLE: if (count < CW'(DEPTH)) state_q <= REQ;
            REQ:  if (mem_rdy) state_q <= WAIT;
            WAIT: if (valid) begin
               fetch_pc_q <= fetch_pc_q + STEP;
               state_q <= (cnt_nx < CW'(DEPTH)) ? REQ : IDLE;
            end
            DROP: if (valid) state_q <= REQ;
         endcase
      end
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb_fetch_prefetch_unit: directed bench with a small memory responder and an in-order fetch address model
module tb_fetch_prefetch_unit;
   logic clk = 0, rst = 1, j = 0, mem_rdy = 0, valid = 0, id_ready = 0;
   logic [31:0] jPC = 0, Rdata = 0;
   logic proc_req, we, if_valid;
   logic [31:0] addr, IR, PC, NPC;
   int checks = 0, errors = 0, pops = 0, accs = 0, pend = 0, resp_dly = 1;
   int n0, p0;
   logic [31:0] exp_pc = 0, acc_addr = 0, a;

   fetch_prefetch_unit #(.bits(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
      .clk      (clk),
      .rst      (rst),
      .j        (j),
      .jPC      (jPC),
      .mem_rdy  (mem_rdy),
      .valid    (valid),
      .Rdata    (Rdata),
      .proc_req (proc_req),
      .we       (we),
      .addr     (addr),
      .if_valid (if_valid),
      .id_ready (id_ready),
      .IR       (IR),
      .PC       (PC),
      .NPC      (NPC)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] ad);
      return ad ^ 32'hC0DE_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // one clock: sample mid-cycle, check any pop against the model, then update the responder
   task automatic tick();
      logic acc;
      #3;
      acc = proc_req & mem_rdy;
      if (acc) begin
         acc_addr = addr;
         accs++;
      end
      if (if_valid && id_ready && !j) begin
         chk("pop_pc", PC, exp_pc);
         chk("pop_ir", IR, mem_word(exp_pc));
         chk("pop_npc", NPC, exp_pc + 32'd4);
         exp_pc += 32'd4;
         pops++;
      end
      if (j) exp_pc = jPC & ~32'd3;
      @(posedge clk);
      #1;
      valid = 0;
      j = 0;
      if (acc) pend = resp_dly;
      if (pend > 0) begin
         pend--;
         if (pend == 0) begin
            valid = 1;
            Rdata = mem_word(acc_addr);
         end
      end
   endtask

   task automatic wait_acc(output logic [31:0] ad);
      int s;
      s = accs;
      for (int i = 0; i < 30 && accs == s; i++) tick();
      chk("acc_seen", 32'(accs != s), 1);
      ad = acc_addr;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog");
      $fatal(1, "timeout");
   end

   initial begin
      #2;
      chk("rst_req", proc_req, 0);
      chk("rst_ifv", if_valid, 0);
      chk("rst_ir", IR, 0);
      chk("rst_pc", PC, 0);
      chk("rst_npc", NPC, 0);
      chk("we", we, 0);
      @(posedge clk);
      #1;
      rst = 0;
      // 1: streaming fetch from RESET_PC
      mem_rdy = 1;
      id_ready = 1;
      resp_dly = 1;
      chk("t1_idle", proc_req, 0);
      tick();
      chk("t1_req", proc_req, 1);
      chk("t1_addr", addr, 0);
      repeat (30) tick();
      chk("t1_pops", 32'(pops >= 10), 1);
      // 2: decode stalled, queue fills to DEPTH and requests stop
      id_ready = 0;
      j = 1;
      jPC = 32'h40;
      tick();
      n0 = accs;
      repeat (20) tick();
      chk("t2_accs", 32'(accs - n0), 4);
      chk("t2_req", proc_req, 0);
      chk("t2_head", PC, 32'h40);
      id_ready = 1;
      p0 = pops;
      repeat (20) tick();
      chk("t2_resume", 32'(pops - p0 >= 8), 1);
      // 3: memory not ready, request held stable
      mem_rdy = 0;
      for (int i = 0; i < 10 && !proc_req; i++) tick();
      chk("t3_reqrise", proc_req, 1);
      a = addr;
      n0 = accs;
      repeat (5) begin
         tick();
         chk("t3_req", proc_req, 1);
         chk("t3_addr", addr, a);
      end
      mem_rdy = 1;
      tick();
      chk("t3_one", 32'(accs - n0), 1);
      chk("t3_wait", proc_req, 0);
      repeat (6) tick();
      // 4: redirect in WAIT, late response dropped
      resp_dly = 3;
      id_ready = 0;
      wait_acc(a);
      wait_acc(a);
      j = 1;
      jPC = 32'h100;
      tick();
      chk("t4_flush", if_valid, 0);
      chk("t4_drop", proc_req, 0);
      tick();
      chk("t4_late", valid, 1);
      id_ready = 1;
      resp_dly = 1;
      wait_acc(a);
      chk("t4_addr", a, 32'h100);
      p0 = pops;
      repeat (10) tick();
      chk("t4_pops", 32'(pops - p0 >= 3), 1);
      // 5: redirect on the same edge as a push and a pop
      id_ready = 0;
      for (int i = 0; i < 30 && !(valid && if_valid); i++) tick();
      chk("t5_setup", 32'(valid && if_valid), 1);
      id_ready = 1;
      j = 1;
      jPC = 32'h203;
      tick();
      chk("t5_empty", if_valid, 0);
      wait_acc(a);
      chk("t5_addr", a, 32'h200);
      p0 = pops;
      repeat (10) tick();
      chk("t5_pops", 32'(pops - p0 >= 3), 1);
      // 6: async reset mid-WAIT, then a stray response in IDLE
      id_ready = 0;
      resp_dly = 3;
      wait_acc(a);
      wait_acc(a);
      chk("t6_pre", if_valid, 1);
      #2;
      rst = 1;
      #1;
      chk("t6_req", proc_req, 0);
      chk("t6_ifv", if_valid, 0);
      chk("t6_ir", IR, 0);
      chk("t6_pc", PC, 0);
      chk("t6_npc", NPC, 0);
      @(posedge clk);
      #1;
      rst = 0;
      pend = 0;
      valid = 1;
      Rdata = 32'hBAD0_BAD0;
      exp_pc = 0;
      tick();
      chk("t6_ifv2", if_valid, 0);
      chk("t6_req2", proc_req, 1);
      chk("t6_addr", addr, 0);
      id_ready = 1;
      resp_dly = 1;
      p0 = pops;
      repeat (12) tick();
      chk("t6_pops", 32'(pops - p0 >= 3), 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
